mem_writer: RTL and testbench
=============================

// Module: mem_writer
// PURPOSE
//  Loads the two dot-product operand vectors into mem1/mem2 before mem_reader streams them out.
//  Accepts one (a,b) element pair per valid/ready handshake and writes a into mem1, b into mem2
//  at the same address, sequentially from 0.
//  Signals completion with writing_done, which the top level uses to launch start_reading.
// PARAMETERS
//  DATA_WIDTH    8                         element width, bits
//  VECTOR_WIDTH  4                         elements per vector; element_count wraps here
//  DEPTH         VECTOR_WIDTH*DATA_WIDTH   words per memory (32)
//  ADDR_WIDTH    5                         memory address width; DEPTH <= 2**ADDR_WIDTH
// PORTS
//  clk            in   1            clock; one clock; all logic on posedge clk
//  rst            in   1            reset is synchronous and active-high
//  start_writing  in   1            pulse: begin a load; ignored unless idle
//  in_valid       in   1            input pair valid
//  in_ready       out  1            block accepts a pair this cycle
//  in_data_a      in   DATA_WIDTH   element for mem1
//  in_data_b      in   DATA_WIDTH   element for mem2
//  in_last        in   1            producer marks final pair
//  wr_en_mem1     out  1            mem1 write enable
//  wr_en_mem2     out  1            mem2 write enable
//  wr_addr_mem1   out  ADDR_WIDTH   mem1 write address
//  wr_addr_mem2   out  ADDR_WIDTH   mem2 write address
//  wr_data_mem1   out  DATA_WIDTH   mem1 write data
//  wr_data_mem2   out  DATA_WIDTH   mem2 write data
//  element_count  out  3            index within current vector of last written pair
//  words_written  out  ADDR_WIDTH+1 pairs written in current/last load
//  writing_done   out  1            one-cycle pulse: load complete, last write committed
//  len_err        out  1            sticky: in_last disagreed with DEPTH; cleared by next start
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; internal counter 0. Reset mid-load aborts it:
//    no writing_done, memory holds partial contents.
//  - States IDLE -> WRITE -> DONE -> IDLE.
//  - IDLE: in_ready=0; in_valid ignored. start_writing=1 -> WRITE; counter, element_count,
//    words_written, len_err <= 0.
//  - WRITE: in_ready=1 (decoded from state). Handshake = in_valid & in_ready at cycle t:
//    at t+1 wr_en_mem1=wr_en_mem2=1, both addrs=counter, data=in_data_a/b; counter++,
//    words_written++. element_count = VECTOR_WIDTH-1 ? 0 : +1 (first write shows 0).
//    No handshake -> wr_en=0 next cycle; address/data hold.
//  - Termination at handshake t: counter==DEPTH-1 or in_last=1 -> DONE at t+1, in_ready=0.
//    len_err<=1 if (in_last=1 & counter<DEPTH-1) or (in_last=0 & counter==DEPTH-1).
//  - DONE (t+1, final write on bus): writing_done=1 at t+2, one cycle; state IDLE at t+2.
//  - start_writing outside IDLE ignored, including same cycle as writing_done.
//  - Mem1 and mem2 write strobes/addresses always identical; counter never exceeds DEPTH-1.
//  - All outputs registered except in_ready.
// STRUCTURE
//  - Shared package dot_pkg: DATA_WIDTH, VECTOR_WIDTH, DEPTH, ADDR_WIDTH defaults, state enum
//    {IDLE,WRITE,DONE}; shared with mem_reader.
//  - Optional sub-module vec_addr_counter (address + element_count wrap), reusable by reader.
//  - Memories are not instantiated here; top wires write ports to mem1/mem2.
// TESTING
//  1 start, 32 back-to-back pairs a=i,b=2i, in_last on i=31 -> writes addr 0..31,
//    writing_done 2 cycles after last handshake, words_written=32, len_err=0.
//  2 Same load, in_valid toggled 1/0 -> wr_en only after handshakes, addrs contiguous, data correct.
//  3 in_last on 10th pair -> DONE, words_written=10, len_err=1; no 11th write.
//  4 32 pairs, no in_last -> done after 32nd, len_err=1; next start clears len_err to 0.
//  5 in_valid=1 while IDLE, start_writing mid-load -> in_ready=0/no writes; restart ignored.
//  6 rst=1 after 5th handshake -> next cycle all outputs 0, no writing_done; new start writes from addr 0.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared dot-product parameters, FSM state encoding and write-beat payload.
// Used by both the memory writer and the memory reader.
package dot_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned VECTOR_WIDTH = 4;
  localparam int unsigned DEPTH        = VECTOR_WIDTH * DATA_WIDTH;
  localparam int unsigned ADDR_WIDTH   = 5;
  localparam int unsigned ELEM_WIDTH   = 3;
  localparam int unsigned WORDS_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
  } wr_beat_t;

  // A load is malformed when in_last and the final address disagree.
  function automatic logic len_mismatch(input logic last, input logic at_end);
    return last ^ at_end;
  endfunction

endpackage

// File: rtl/mem_writer_if.sv
// Operand stream, dual memory write port and status bundle of the memory writer.
interface mem_writer_if;
  import dot_pkg::*;

  logic                   start_writing;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data_a;
  logic [DATA_WIDTH-1:0]  in_data_b;
  logic                   in_last;
  logic                   wr_en_mem1;
  logic                   wr_en_mem2;
  logic [ADDR_WIDTH-1:0]  wr_addr_mem1;
  logic [ADDR_WIDTH-1:0]  wr_addr_mem2;
  logic [DATA_WIDTH-1:0]  wr_data_mem1;
  logic [DATA_WIDTH-1:0]  wr_data_mem2;
  logic [ELEM_WIDTH-1:0]  element_count;
  logic [WORDS_WIDTH-1:0] words_written;
  logic                   writing_done;
  logic                   len_err;

  modport master (
    output start_writing, in_valid, in_data_a, in_data_b, in_last,
    input  in_ready, wr_en_mem1, wr_en_mem2, wr_addr_mem1, wr_addr_mem2,
           wr_data_mem1, wr_data_mem2, element_count, words_written,
           writing_done, len_err
  );

  modport slave (
    input  start_writing, in_valid, in_data_a, in_data_b, in_last,
    output in_ready, wr_en_mem1, wr_en_mem2, wr_addr_mem1, wr_addr_mem2,
           wr_data_mem1, wr_data_mem2, element_count, words_written,
           writing_done, len_err
  );

endinterface

// File: rtl/vec_addr_counter.sv
// Sequential memory address with a per-vector element index that wraps at VECTOR_WIDTH.
// The address saturates at DEPTH-1 so it never leaves the memory.
module vec_addr_counter
  import dot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ELEM_WIDTH-1:0] o_elem,
  output logic                  o_at_end_c
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ELEM_WIDTH-1:0] r_elem;
  logic                  w_at_end;
  logic                  w_elem_wrap;

  assign w_at_end    = (r_addr == ADDR_WIDTH'(DEPTH - 1));
  assign w_elem_wrap = (r_elem == ELEM_WIDTH'(VECTOR_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_addr <= '0;
      r_elem <= '0;
    end else if (i_advance) begin
      if (!w_at_end) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      r_elem <= w_elem_wrap ? '0 : r_elem + ELEM_WIDTH'(1);
    end
  end

  assign o_addr     = r_addr;
  assign o_elem     = r_elem;
  assign o_at_end_c = w_at_end;

endmodule

// File: rtl/mem_writer.sv
// Loads operand pairs into mem1/mem2 at sequential addresses and pulses writing_done
// once the final write has been committed.
module mem_writer
  import dot_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_writer_if.slave   bus
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_in_ready;
  logic                   w_hs;
  logic                   w_clear;
  logic                   w_last_write;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [ELEM_WIDTH-1:0]  w_elem;
  logic                   w_at_end;

  wr_beat_t               r_beat;
  logic                   r_wr_en;
  logic [ELEM_WIDTH-1:0]  r_element_count;
  logic [WORDS_WIDTH-1:0] r_words_written;
  logic                   r_writing_done;
  logic                   r_len_err;

  vec_addr_counter u_addr (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_advance  (w_hs),
    .o_addr     (w_addr),
    .o_elem     (w_elem),
    .o_at_end_c (w_at_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A start is refused while writing_done is still showing, so one load cannot chain into the next.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_hs         = 1'b0;
    w_clear      = 1'b0;
    w_last_write = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_writing && !r_writing_done) begin
          w_clear      = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_in_ready = 1'b1;
        w_hs       = bus.in_valid;
        if (w_hs && (bus.in_last || w_at_end)) begin
          w_last_write = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Write port and status registers; address/data hold between handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat          <= '0;
      r_wr_en         <= 1'b0;
      r_element_count <= '0;
      r_words_written <= '0;
      r_writing_done  <= 1'b0;
      r_len_err       <= 1'b0;
    end else begin
      r_wr_en        <= w_hs;
      r_writing_done <= (r_state == DONE);
      if (w_clear) begin
        r_element_count <= '0;
        r_words_written <= '0;
        r_len_err       <= 1'b0;
      end
      if (w_hs) begin
        r_beat.addr     <= w_addr;
        r_beat.data_a   <= bus.in_data_a;
        r_beat.data_b   <= bus.in_data_b;
        r_element_count <= w_elem;
        r_words_written <= r_words_written + WORDS_WIDTH'(1);
      end
      if (w_last_write) begin
        r_len_err <= len_mismatch(bus.in_last, w_at_end);
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.wr_en_mem1    = r_wr_en;
  assign bus.wr_en_mem2    = r_wr_en;
  assign bus.wr_addr_mem1  = r_beat.addr;
  assign bus.wr_addr_mem2  = r_beat.addr;
  assign bus.wr_data_mem1  = r_beat.data_a;
  assign bus.wr_data_mem2  = r_beat.data_b;
  assign bus.element_count = r_element_count;
  assign bus.words_written = r_words_written;
  assign bus.writing_done  = r_writing_done;
  assign bus.len_err       = r_len_err;

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: full, throttled, short, overlong and aborted loads.
module tb_mem_writer;
  import dot_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_writer_if bus ();

  mem_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m1 [32];
  logic [7:0] m2 [32];
  int n_writes = 0;
  int exp_addr = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: both ports in lockstep, addresses contiguous from 0.
  always @(negedge clk) begin
    if (bus.writing_done === 1'b1) done_cnt++;
    if (bus.wr_en_mem1 === 1'b1 || bus.wr_en_mem2 === 1'b1) begin
      check("wr_en_pair", 32'(bus.wr_en_mem2), 32'(bus.wr_en_mem1));
      check("addr_pair", 32'(bus.wr_addr_mem2), 32'(bus.wr_addr_mem1));
      check("addr_seq", 32'(bus.wr_addr_mem1), exp_addr);
      m1[bus.wr_addr_mem1] = bus.wr_data_mem1;
      m2[bus.wr_addr_mem1] = bus.wr_data_mem2;
      n_writes++;
      exp_addr++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    tick();
    exp_addr = 0;
    n_writes = 0;
    for (int i = 0; i < 32; i++) begin
      m1[i] = 'x;
      m2[i] = 'x;
    end
    bus.start_writing = 1'b1;
    tick();
    bus.start_writing = 1'b0;
  endtask

  task automatic send(input int i, input bit last, input bit gap);
    int w;
    w = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid  = 1'b1;
    bus.in_data_a = 8'(i);
    bus.in_data_b = 8'(2 * i);
    bus.in_last   = last;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) check("ready_timeout", 32'(bus.in_ready), 1);
    tick();
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) begin
      check("mem1", 32'(m1[i]), i);
      check("mem2", 32'(m2[i]), 2 * i);
    end
  endtask

  // Called one cycle after the terminating handshake.
  task automatic finish_load(input int n, input bit exp_len_err, input int exp_elem, input bit poke);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("in_ready_done", 32'(bus.in_ready), 0);
    check("wr_en_last", 32'(bus.wr_en_mem1), 1);
    check("words_written", 32'(bus.words_written), n);
    check("len_err", 32'(bus.len_err), 32'(exp_len_err));
    check("element_count", 32'(bus.element_count), exp_elem);
    check("done_early", 32'(bus.writing_done), 0);
    tick();
    check("writing_done", 32'(bus.writing_done), 1);
    check("wr_en_after", 32'(bus.wr_en_mem1), 0);
    bus.start_writing = poke;
    tick();
    bus.start_writing = 1'b0;
    check("done_pulse", 32'(bus.writing_done), 0);
    check("idle_ready", 32'(bus.in_ready), 0);
    check("n_writes", n_writes, n);
    check_mem(n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_wr_en1"}, 32'(bus.wr_en_mem1), 0);
    check({tag, "_wr_en2"}, 32'(bus.wr_en_mem2), 0);
    check({tag, "_addr1"}, 32'(bus.wr_addr_mem1), 0);
    check({tag, "_addr2"}, 32'(bus.wr_addr_mem2), 0);
    check({tag, "_data1"}, 32'(bus.wr_data_mem1), 0);
    check({tag, "_data2"}, 32'(bus.wr_data_mem2), 0);
    check({tag, "_elem"}, 32'(bus.element_count), 0);
    check({tag, "_words"}, 32'(bus.words_written), 0);
    check({tag, "_done"}, 32'(bus.writing_done), 0);
    check({tag, "_len_err"}, 32'(bus.len_err), 0);
  endtask

  initial begin
    int done_before;
    rst               = 1'b1;
    bus.start_writing = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data_a     = '0;
    bus.in_data_b     = '0;
    bus.in_last       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // Idle: valid pairs are not accepted.
    n_writes     = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    check("idle_no_writes", n_writes, 0);

    // Back-to-back full load; start on the writing_done cycle is ignored.
    do_start();
    for (int i = 0; i < 32; i++) send(i, i == 31, 1'b0);
    finish_load(32, 1'b0, 3, 1'b1);

    // Throttled full load.
    do_start();
    for (int i = 0; i < 32; i++) send(i, i == 31, 1'b1);
    finish_load(32, 1'b0, 3, 1'b0);

    // Early in_last on the 10th pair.
    do_start();
    for (int i = 0; i < 10; i++) send(i, i == 9, 1'b0);
    finish_load(10, 1'b1, 1, 1'b0);

    // Full depth without in_last, then the next start clears len_err.
    do_start();
    for (int i = 0; i < 32; i++) send(i, 1'b0, 1'b0);
    finish_load(32, 1'b1, 3, 1'b0);
    do_start();
    check("len_err_cleared", 32'(bus.len_err), 0);

    // Restart pulse mid-load is ignored.
    for (int i = 0; i < 32; i++) begin
      bus.start_writing = (i == 3);
      send(i, i == 31, 1'b0);
      bus.start_writing = 1'b0;
    end
    finish_load(32, 1'b0, 3, 1'b0);

    // Reset after the 5th handshake aborts the load.
    do_start();
    for (int i = 0; i < 5; i++) send(i, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    done_before  = done_cnt;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("abort");
    tick();
    tick();
    check("abort_no_done", done_cnt, done_before);
    do_start();
    for (int i = 0; i < 4; i++) send(i, i == 3, 1'b0);
    finish_load(4, 1'b1, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
